// File: rtl/noc_vchannel_mux.sv
// Multiplexes VCHANNELS virtual channels onto one registered link with round-robin arbitration.
// Optional packet locking is enabled by defining NOC_VCMUX_PACKET_LOCK_EN.

module noc_vcmux_lane (
  input  logic valid,
  input  logic ready,
  input  logic lock_ok,
  output logic elig
);
  assign elig = valid & ready & lock_ok;
endmodule

module noc_vchannel_mux #(
  parameter int FLIT_WIDTH = 32,
  parameter int VCHANNELS  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [VCHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0]                 in_last,
  input  logic [VCHANNELS-1:0]                 in_valid,
  output logic [VCHANNELS-1:0]                 in_ready,
  output logic [FLIT_WIDTH-1:0]                out_flit,
  output logic                                 out_last,
  output logic [VCHANNELS-1:0]                 out_valid,
  input  logic [VCHANNELS-1:0]                 out_ready
);
  localparam int VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

  logic [FLIT_WIDTH-1:0] flit_q;
  logic                  last_q;
  logic [VW-1:0]         vc_q;
  logic                  full_q;
  logic [VW-1:0]         rr_ptr;
  logic [VW-1:0]         rr_next;
  logic [VCHANNELS-1:0]  elig;
  logic [VCHANNELS-1:0]  lock_ok;
  logic [VW-1:0]         grant;
  logic                  grant_vld;
  logic                  drain;
  logic                  accept;

`ifdef NOC_VCMUX_PACKET_LOCK_EN
  logic          lock_q;
  logic [VW-1:0] lock_vc;

  always_comb begin
    for (int v = 0; v < VCHANNELS; v++)
      lock_ok[v] = !lock_q || (VW'(v) == lock_vc);
  end

  // Lock opens on a non-last flit and closes when the locked VC sends its last flit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q  <= 1'b0;
      lock_vc <= '0;
    end else if (accept) begin
      if (in_last[grant]) begin
        lock_q <= 1'b0;
      end else begin
        lock_q  <= 1'b1;
        lock_vc <= grant;
      end
    end
  end
`else
  assign lock_ok = '1;
`endif

  noc_vcmux_lane u_lane [VCHANNELS-1:0] (
    .valid   (in_valid),
    .ready   (out_ready),
    .lock_ok (lock_ok),
    .elig    (elig)
  );

  // First eligible VC at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int i = 0; i < VCHANNELS; i++) begin
      idx = (int'(rr_ptr) + i) % VCHANNELS;
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant     = VW'(idx);
      end
    end
  end

  assign rr_next = (grant == VW'(VCHANNELS - 1)) ? '0 : grant + VW'(1);
  assign drain   = full_q && out_ready[vc_q];
  assign accept  = rst && (!full_q || drain) && grant_vld;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  always_comb begin
    out_valid = '0;
    if (rst && full_q) out_valid[vc_q] = 1'b1;
  end

  assign out_flit = flit_q;
  assign out_last = last_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q <= 1'b0;
      vc_q   <= '0;
      rr_ptr <= '0;
      flit_q <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      flit_q <= in_flit[grant];
      last_q <= in_last[grant];
      vc_q   <= grant;
      full_q <= 1'b1;
      rr_ptr <= rr_next;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end
endmodule

// File: doc/noc_vchannel_mux.md
NOC_VCHANNEL_MUX -- requirements
Module: noc_vchannel_mux

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32: flit data width in bits.
REQ-002 SHALL have parameter VCHANNELS, default 2: number of virtual channels multiplexed onto one link; legal range 1..8.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port in_flit, input, [VCHANNELS-1:0][FLIT_WIDTH-1:0]: flit offered per VC, taken from the router output stage.
REQ-006 SHALL have port in_last, input, [VCHANNELS-1:0]: last flit of a packet, per VC.
REQ-007 SHALL have port in_valid, input, [VCHANNELS-1:0]: flit offered, per VC.
REQ-008 SHALL have port in_ready, output, [VCHANNELS-1:0]: flit accepted, per VC; at most one bit high per cycle.
REQ-009 SHALL have port out_flit, output, [FLIT_WIDTH-1:0]: registered link flit.
REQ-010 SHALL have port out_last, output, 1: registered last marker.
REQ-011 SHALL have port out_valid, output, [VCHANNELS-1:0]: one-hot VC tag of the registered flit; all-zero when empty.
REQ-012 SHALL have port out_ready, input, [VCHANNELS-1:0]: downstream space available, per VC.

Function
REQ-013 SHALL hold one output register: flit, last, VC index vc_q and full flag full_q; out_valid = full_q ? onehot(vc_q) : 0.
REQ-014 SHALL drain the register in a cycle where full_q && out_ready[vc_q] is true.
REQ-015 SHALL permit a new accept only when !full_q, or when the register drains in that same cycle; back-to-back flits at one per cycle are sustained.
REQ-016 SHALL treat VC v as eligible when in_valid[v] && out_ready[v], and (when the lock is active) v == lock_vc.
REQ-017 SHALL grant among eligible VCs round-robin: the search starts at rr_ptr, and after a grant to v, rr_ptr becomes (v+1) mod VCHANNELS.
REQ-018 SHALL assert in_ready[v] combinationally only for the granted VC in an accept cycle, and load that VC's flit, last and index into the register at the next edge.
REQ-019 SHALL give latency of exactly 1 cycle from the in_valid&&in_ready handshake to the flit appearing on out_*.
REQ-020 SHALL leave the register unchanged while full_q && !out_ready[vc_q]; the other VCs are blocked for that time (documented head-of-line limitation).
REQ-021 SHALL make rr_ptr unchanged in any cycle with no grant.
REQ-022 SHALL, with VCHANNELS=1, reduce to a one-stage pipeline register with rr_ptr constant 0.

Reset
REQ-023 SHALL, while rst=0 at a clock edge, set full_q=0, vc_q=0, rr_ptr=0, lock released, out_flit=0, out_last=0; hence out_valid=0 and in_ready=0 during reset.
REQ-024 SHALL discard a registered or partially transferred packet on reset mid-operation; no flit is emitted on the first cycle after reset.

Configuration
REQ-025 SHALL, when macro NOC_VCMUX_PACKET_LOCK_EN is defined, lock arbitration on accepting a flit with in_last=0: lock_vc = granted VC, held until the flit with in_last=1 is accepted from lock_vc; a single-flit packet (first flit with in_last=1) never locks.
REQ-026 SHALL, when NOC_VCMUX_PACKET_LOCK_EN is undefined, arbitrate per flit, so packets of different VCs may interleave on the link; no lock state is implemented.

Verification (FLIT_WIDTH=32, VCHANNELS=2)
REQ-027 SHALL cover: rst=0 for 3 cycles with in_valid=2'b11 -> out_valid=0 and in_ready=0 throughout; first accept occurs on the first cycle after rst=1.
REQ-028 SHALL cover: VC0 and VC1 both continuously valid with single-flit packets 0xA0.., 0xB0.., out_ready=2'b11, lock undefined -> link sequence VC0,VC1,VC0,VC1 at one flit per cycle, out_valid alternating 01/10.
REQ-029 SHALL cover: lock defined, VC0 3-flit packet 0x01,0x02,0x03(last) against a VC1 flit 0x10 ready simultaneously -> link order 0x01,0x02,0x03,0x10.
REQ-030 SHALL cover: the register holds VC1 flit 0x55 with out_ready=2'b01 for 4 cycles -> out_flit stable at 0x55, in_ready=0; when out_ready goes to 2'b11, 0x55 drains and the next flit appears the following cycle.
REQ-031 SHALL cover: out_ready[0]=0 with in_valid=2'b11 -> only VC1 is granted; VC0 is never granted until out_ready[0]=1.
REQ-032 SHALL cover: rst=0 asserted while the lock is held mid-packet -> after reset, lock released, rr_ptr=0, and VC0 wins the first contested grant.
